// File: rtl/max_pooling_mult.sv
// 1-D 2:1 max pooling over packed IEEE-754 elements.
// Each output lane holds the larger of one adjacent input pair under
// sign-magnitude ordering. NaN and Inf are ordered by their bit patterns
// like any other value. The result is registered with a latency of one cycle.
module max_pooling_mult #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_COUNT   = 48,
    parameter int OUT_COUNT  = 24
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            valid_i,
    input  logic [IN_COUNT*DATA_WIDTH-1:0]  multi_input_data,
    output logic                            valid_o,
    output logic [OUT_COUNT*DATA_WIDTH-1:0] multi_output_data
);

    logic [OUT_COUNT*DATA_WIDTH-1:0] pooled;

    // Pick the winner of each pair; the odd element wins unless the even one is strictly greater
    always_comb begin
        pooled = '0;
        for (int unsigned i = 0; i < OUT_COUNT; i++) begin
            logic [DATA_WIDTH-1:0] a;
            logic [DATA_WIDTH-1:0] b;
            logic                  a_gt_b;
            a = multi_input_data[(2*i)*DATA_WIDTH +: DATA_WIDTH];
            b = multi_input_data[(2*i+1)*DATA_WIDTH +: DATA_WIDTH];
            if (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) begin
                // Differing signs: the non-negative element wins, which also makes +0 beat -0
                a_gt_b = ~a[DATA_WIDTH-1];
            end else if (!a[DATA_WIDTH-1]) begin
                a_gt_b = a[DATA_WIDTH-2:0] > b[DATA_WIDTH-2:0];
            end else begin
                a_gt_b = a[DATA_WIDTH-2:0] < b[DATA_WIDTH-2:0];
            end
            pooled[i*DATA_WIDTH +: DATA_WIDTH] = a_gt_b ? a : b;
        end
    end

    // Output register: reset clears, valid loads, otherwise data holds and valid drops
    always_ff @(posedge clk) begin
        if (!reset) begin
            multi_output_data <= '0;
            valid_o           <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                multi_output_data <= pooled;
            end
        end
    end

endmodule

// File: tb/tb_max_pooling_mult.sv
// Self-checking bench for max_pooling_mult: directed cases plus a random
// stream compared against a value-ordering reference model.
module tb_max_pooling_mult;

    localparam int DW = 32;
    localparam int IC = 48;
    localparam int OC = 24;

    logic               clk;
    logic               reset;
    logic               valid_i;
    logic [IC*DW-1:0]   din;
    logic               valid_o;
    logic [OC*DW-1:0]   dout;

    logic [OC*DW-1:0]   exp_out;
    logic               exp_v;
    int                 total;
    int                 bad;

    max_pooling_mult #(
        .DATA_WIDTH (DW),
        .IN_COUNT   (IC),
        .OUT_COUNT  (OC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .valid_i           (valid_i),
        .multi_input_data  (din),
        .valid_o           (valid_o),
        .multi_output_data (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Map a bit pattern onto a signed integer whose order is the required float order;
    // -0 sits just below +0.
    function automatic longint order_key(input logic [DW-1:0] x);
        longint mag;
        mag = longint'({33'b0, x[DW-2:0]});
        return x[DW-1] ? (-mag - 1) : mag;
    endfunction

    function automatic logic [OC*DW-1:0] pool_ref(input logic [IC*DW-1:0] d);
        logic [OC*DW-1:0] r;
        logic [DW-1:0]    a;
        logic [DW-1:0]    b;
        r = '0;
        for (int i = 0; i < OC; i++) begin
            a = d[(2*i)*DW +: DW];
            b = d[(2*i+1)*DW +: DW];
            r[i*DW +: DW] = (order_key(a) > order_key(b)) ? a : b;
        end
        return r;
    endfunction

    function automatic logic [IC*DW-1:0] fill_pairs(input logic [DW-1:0] even_v,
                                                    input logic [DW-1:0] odd_v);
        logic [IC*DW-1:0] d;
        d = '0;
        for (int i = 0; i < OC; i++) begin
            d[(2*i)*DW +: DW]   = even_v;
            d[(2*i+1)*DW +: DW] = odd_v;
        end
        return d;
    endfunction

    function automatic logic [OC*DW-1:0] fill_out(input logic [DW-1:0] v);
        logic [OC*DW-1:0] r;
        for (int i = 0; i < OC; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [IC*DW-1:0] rand_data();
        logic [IC*DW-1:0] d;
        for (int k = 0; k < IC; k++) d[k*DW +: DW] = $urandom();
        return d;
    endfunction

    // Advance one clock and apply the expected-behaviour rules to the reference state
    task automatic step();
        @(posedge clk);
        if (!reset) begin
            exp_out = '0;
            exp_v   = 1'b0;
        end else if (valid_i) begin
            exp_out = pool_ref(din);
            exp_v   = 1'b1;
        end else begin
            exp_v   = 1'b0;
        end
        #1;
    endtask

    task automatic check_data(input string tag, input logic [OC*DW-1:0] obs,
                              input logic [OC*DW-1:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic check_model(input string tag);
        check_bit({tag, "_valid"}, valid_o, exp_v);
        check_data({tag, "_data"}, dout, exp_out);
    endtask

    initial begin
        logic [IC*DW-1:0] d;
        logic [OC*DW-1:0] e;
        int               n_rand;
        total   = 0;
        bad     = 0;
        exp_out = '0;
        exp_v   = 1'b0;

        // Reset held low with valid data present
        reset   = 1'b0;
        valid_i = 1'b1;
        din     = rand_data();
        step();
        check_bit("rst0_valid", valid_o, 1'b0);
        check_data("rst0_data", dout, '0);
        din = rand_data();
        step();
        check_bit("rst1_valid", valid_o, 1'b0);
        check_data("rst1_data", dout, '0);

        // Positive beats negative with identical magnitude
        reset   = 1'b1;
        valid_i = 1'b1;
        din     = fill_pairs(32'h8C000000, 32'h0C000000);
        step();
        check_bit("signdiff_valid", valid_o, 1'b1);
        check_data("signdiff_data", dout, fill_out(32'h0C000000));

        // Gap: output holds, valid drops
        valid_i = 1'b0;
        din     = rand_data();
        step();
        check_bit("gap_valid", valid_o, 1'b0);
        check_data("gap_hold", dout, fill_out(32'h0C000000));

        // Even element larger among positives
        valid_i = 1'b1;
        din     = fill_pairs(32'h0B000000, 32'h0A000000);
        step();
        check_bit("pos_valid", valid_o, 1'b1);
        check_data("pos_data", dout, fill_out(32'h0B000000));

        // Per-lane sign cases, rotated through the lanes
        d = '0;
        e = '0;
        for (int i = 0; i < OC; i++) begin
            case (i % 4)
                0: begin
                    d[(2*i)*DW +: DW] = 32'hBF800000; d[(2*i+1)*DW +: DW] = 32'hC0000000;
                    e[i*DW +: DW] = 32'hBF800000;
                end
                1: begin
                    d[(2*i)*DW +: DW] = 32'h00000000; d[(2*i+1)*DW +: DW] = 32'h80000000;
                    e[i*DW +: DW] = 32'h00000000;
                end
                2: begin
                    d[(2*i)*DW +: DW] = 32'h80000000; d[(2*i+1)*DW +: DW] = 32'h00000000;
                    e[i*DW +: DW] = 32'h00000000;
                end
                default: begin
                    d[(2*i)*DW +: DW] = 32'h3F800000; d[(2*i+1)*DW +: DW] = 32'h3F800000;
                    e[i*DW +: DW] = 32'h3F800000;
                end
            endcase
        end
        din = d;
        step();
        check_bit("lanes_valid", valid_o, 1'b1);
        check_data("lanes_data", dout, e);

        // Negatives: the smaller magnitude wins, in either position
        din = fill_pairs(32'hC0000000, 32'hBF800000);
        step();
        check_data("neg_odd_data", dout, fill_out(32'hBF800000));

        // Random stream with random valid
        n_rand = 0;
        repeat (1000) begin
            valid_i = $urandom_range(0, 1) == 1;
            din     = rand_data();
            step();
            check_model("rand");
            n_rand++;
        end
        check_bit("rand_count", n_rand == 1000, 1'b1);

        // Reset asserted mid-stream
        valid_i = 1'b1;
        din     = rand_data();
        step();
        check_model("pre_rst");
        reset = 1'b0;
        din   = rand_data();
        step();
        check_bit("midrst_valid", valid_o, 1'b0);
        check_data("midrst_data", dout, '0);
        reset = 1'b1;
        din   = rand_data();
        step();
        check_model("post_rst");
        check_data("post_rst_ref", dout, pool_ref(din));
        din = rand_data();
        step();
        check_model("post_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/max_pooling_mult.md
MAX_POOLING_MULT -- requirements
Module: max_pooling_mult

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the element width (IEEE-754 single).
REQ-002 The block SHALL have parameter IN_COUNT, default 48, meaning the number of input elements (even).
REQ-003 The block SHALL have parameter OUT_COUNT, default 24, meaning the number of output elements (IN_COUNT/2).
REQ-004 clk  input  1  rising-edge clock; the block SHALL use one clock only.
REQ-005 reset  input  1  reset, synchronous and active-low (0 = reset, sampled on rising clk).
REQ-006 valid_i  input  1  input vector valid this cycle.
REQ-007 multi_input_data  input  IN_COUNT*DATA_WIDTH (1536)  packed elements; element k = bits [k*32 +: 32].
REQ-008 valid_o  output  1  multi_output_data holds a newly computed result.
REQ-009 multi_output_data  output  OUT_COUNT*DATA_WIDTH (768)  packed results; element i = bits [i*32 +: 32].

Function
REQ-010 The block SHALL compute, for each i in 0..OUT_COUNT-1, out[i] = max(in[2i], in[2i+1]) under floating-point ordering (1-D 2:1 max pooling).
REQ-011 The comparison SHALL be sign-magnitude: if the signs differ, the element with sign 0 wins.
REQ-012 If both elements are positive, the larger unsigned value of bits [30:0] SHALL win; if both are negative, the smaller value of bits [30:0] SHALL win.
REQ-013 On equal bit patterns, in[2i+1] SHALL be selected; the result is identical either way.
REQ-014 +0 (0x00000000) vs -0 (0x80000000) SHALL yield +0.
REQ-015 NaN and Inf SHALL receive no special handling and SHALL be ordered by the bit-pattern rules of REQ-011 and REQ-012.
REQ-016 The result SHALL be passed through unmodified, with no rounding or normalisation.
REQ-017 All OUT_COUNT lanes SHALL be evaluated in parallel each cycle.
REQ-018 Latency SHALL be 1 cycle: on a rising edge with reset=1 and valid_i=1, multi_output_data SHALL load the pooled result of the current multi_input_data, and valid_o SHALL be set to 1.
REQ-019 On a rising edge with reset=1 and valid_i=0, multi_output_data SHALL hold its previous value, and valid_o SHALL be set to 0.
REQ-020 Back-to-back valid_i SHALL be accepted every cycle; there is no backpressure and no ready signal.
REQ-021 The outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-022 On a rising edge with reset=0, multi_output_data SHALL be set to all zeros and valid_o to 0, regardless of valid_i.
REQ-023 Reset SHALL take priority over valid_i.
REQ-024 Assertion of reset mid-stream SHALL discard any in-flight result.
REQ-025 On the first edge after reset returns to 1, the block SHALL behave per REQ-018 and REQ-019.

Verification
REQ-026 Reset held low for 2 cycles with valid_i=1 and arbitrary data -> multi_output_data=0 and valid_o=0 throughout.
REQ-027 All 24 pairs {in[2i+1], in[2i]} = {0x0C000000, 0x8C000000} with valid_i=1 -> one cycle later every out[i]=0x0C000000 and valid_o=1.
REQ-028 valid_i=0 for one cycle, then all pairs {0x0A000000, 0x0B000000} with valid_i=1 -> during the gap, valid_o=0 and the output holds 0x0C000000; one cycle after the new data, every out[i]=0x0B000000 and valid_o=1.
REQ-029 Per-lane sign cases: {0xC0000000 (-2.0), 0xBF800000 (-1.0)} -> 0xBF800000; {0x80000000, 0x00000000} -> 0x00000000; {0x3F800000, 0x3F800000} -> 0x3F800000.
REQ-030 Distinct random values in each lane, with valid_i toggling randomly for 1000 cycles, compared against a reference max model -> exact bit match for every lane, and valid_o equal to valid_i delayed by one cycle.
REQ-031 reset driven to 0 while valid_i=1 streams -> the next edge yields zero output and valid_o=0, and correct results resume one cycle after reset is released.
